// File: rtl/timer_counter_core_if.sv
// Bus between the timer register block and the counting core: decoded TCR
// fields and TDR in, TCNT and the wrap pulses out.
interface timer_counter_core_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] tdr;
  logic             load;
  logic             updown;
  logic             en;
  logic [1:0]       cks;
  logic [WIDTH-1:0] tcnt;
  logic             ovf;
  logic             udf;

  modport master (
    output tdr, load, updown, en, cks,
    input  tcnt, ovf, udf
  );

  modport slave (
    input  tdr, load, updown, en, cks,
    output tcnt, ovf, udf
  );
endinterface

// File: rtl/timer_counter_core.sv
// Counting core of the 8-bit timer: prescaler, up/down TCNT with reload,
// and single-cycle overflow/underflow pulses.
module timer_counter_core #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  timer_counter_core_if.slave  bus
);

  logic [DIV_W-1:0] r_divCnt;
  logic [WIDTH-1:0] r_tcnt;
  logic             r_ovf;
  logic             r_udf;
  logic [DIV_W-1:0] w_term;
  logic             w_tick;

  always_comb begin
    w_term = DIV_W'(1);
    case (bus.cks)
      2'b00: w_term = DIV_W'(1);
      2'b01: w_term = DIV_W'(3);
      2'b10: w_term = DIV_W'(7);
      2'b11: w_term = DIV_W'(15);
    endcase
  end

  assign w_tick = bus.en & ~bus.load & (r_divCnt == w_term);

  // A lowered cks can leave div_cnt above the new terminal; clear it without ticking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_divCnt <= '0;
    end else if (!bus.en || bus.load) begin
      r_divCnt <= '0;
    end else if (r_divCnt >= w_term) begin
      r_divCnt <= '0;
    end else begin
      r_divCnt <= r_divCnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tcnt <= '0;
      r_ovf  <= 1'b0;
      r_udf  <= 1'b0;
    end else begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
      if (bus.load) begin
        r_tcnt <= bus.tdr;
      end else if (w_tick && !bus.updown) begin
        r_tcnt <= r_tcnt + WIDTH'(1);
        r_ovf  <= (r_tcnt == '1);
      end else if (w_tick && bus.updown) begin
        r_tcnt <= r_tcnt - WIDTH'(1);
        r_udf  <= (r_tcnt == '0);
      end
    end
  end

  assign bus.tcnt = r_tcnt;
  assign bus.ovf  = r_ovf;
  assign bus.udf  = r_udf;

endmodule

// File: tb/tb_timer_counter_core.sv
// Directed bench for timer_counter_core: reset, wrap pulses, enable gating,
// load priority over a due tick, and clock-select changes mid-period.
module tb_timer_counter_core;

  logic clk;
  logic rst;
  int   vecCount;
  int   missCount;

  timer_counter_core_if #(.WIDTH(8)) bus ();

  timer_counter_core #(.WIDTH(8), .DIV_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic iLoad, input logic [7:0] iTdr,
                               input logic iUpdown, input logic iEn,
                               input logic [1:0] iCks);
    bus.load   = iLoad;
    bus.tdr    = iTdr;
    bus.updown = iUpdown;
    bus.en     = iEn;
    bus.cks    = iCks;
  endtask

  task automatic stepClock(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Outputs are sampled 1 time unit after each rising edge.
  initial begin
    int sawOvf;
    int udfCount;
    logic [7:0] expT2 [1:6];
    logic       expO2 [1:6];
    vecCount  = 0;
    missCount = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 2'b00);
    stepClock(2);
    rst = 1'b0;
    checkOutput("reset tcnt", bus.tcnt, 8'h00);
    checkOutput("reset ovf", bus.ovf, 1'b0);
    checkOutput("reset udf", bus.udf, 1'b0);

    // Test 1: async reset mid-count
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0, 2'b00);
    stepClock(1);
    checkOutput("t1 load 5A", bus.tcnt, 8'h5A);
    applyStimulus(1'b0, 8'h5A, 1'b0, 1'b1, 2'b00);
    stepClock(1);
    checkOutput("t1 counting 5A", bus.tcnt, 8'h5A);
    #2 rst = 1'b1;
    #1;
    checkOutput("t1 async tcnt", bus.tcnt, 8'h00);
    checkOutput("t1 async ovf", bus.ovf, 1'b0);
    checkOutput("t1 async udf", bus.udf, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 2'b00);
    stepClock(1);
    #2 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      stepClock(1);
      checkOutput("t1 idle tcnt", bus.tcnt, 8'h00);
    end

    // Test 2: count up through overflow at /2
    applyStimulus(1'b1, 8'hFD, 1'b0, 1'b0, 2'b00);
    stepClock(1);
    checkOutput("t2 load FD", bus.tcnt, 8'hFD);
    applyStimulus(1'b0, 8'hFD, 1'b0, 1'b1, 2'b00);
    expT2 = '{8'hFD, 8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'h00};
    expO2 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 1; k <= 6; k++) begin
      stepClock(1);
      checkOutput("t2 tcnt", bus.tcnt, expT2[k]);
      checkOutput("t2 ovf", bus.ovf, expO2[k]);
      checkOutput("t2 udf", bus.udf, 1'b0);
    end
    stepClock(1);
    checkOutput("t2 ovf one cycle", bus.ovf, 1'b0);
    checkOutput("t2 tcnt hold 00", bus.tcnt, 8'h00);

    // Test 3: count down through underflow at /16
    applyStimulus(1'b1, 8'h02, 1'b1, 1'b0, 2'b11);
    stepClock(1);
    checkOutput("t3 load 02", bus.tcnt, 8'h02);
    applyStimulus(1'b0, 8'h02, 1'b1, 1'b1, 2'b11);
    sawOvf   = 0;
    udfCount = 0;
    for (int k = 1; k <= 49; k++) begin
      stepClock(1);
      if (bus.ovf) sawOvf++;
      if (bus.udf) udfCount++;
      if (k == 15) checkOutput("t3 tcnt@15", bus.tcnt, 8'h02);
      if (k == 16) checkOutput("t3 tcnt@16", bus.tcnt, 8'h01);
      if (k == 31) checkOutput("t3 tcnt@31", bus.tcnt, 8'h01);
      if (k == 32) checkOutput("t3 tcnt@32", bus.tcnt, 8'h00);
      if (k == 47) checkOutput("t3 tcnt@47", bus.tcnt, 8'h00);
      if (k == 48) begin
        checkOutput("t3 tcnt@48", bus.tcnt, 8'hFF);
        checkOutput("t3 udf@48", bus.udf, 1'b1);
      end
      if (k == 49) checkOutput("t3 udf@49", bus.udf, 1'b0);
    end
    checkOutput("t3 ovf never", sawOvf, 0);
    checkOutput("t3 udf count", udfCount, 1);

    // Test 4: enable gating at /4
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 2'b01);
    stepClock(1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 2'b01);
    stepClock(3);
    checkOutput("t4 tcnt@3", bus.tcnt, 8'h00);
    stepClock(1);
    checkOutput("t4 tcnt@4", bus.tcnt, 8'h01);
    stepClock(2);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 2'b01);
    for (int i = 0; i < 5; i++) begin
      stepClock(1);
      checkOutput("t4 frozen", bus.tcnt, 8'h01);
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 2'b01);
    stepClock(3);
    checkOutput("t4 re-en @3", bus.tcnt, 8'h01);
    stepClock(1);
    checkOutput("t4 re-en @4", bus.tcnt, 8'h02);

    // Test 5: load wins over a due tick at all-ones
    applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0, 2'b00);
    stepClock(1);
    applyStimulus(1'b0, 8'hFF, 1'b0, 1'b1, 2'b00);
    stepClock(1);
    checkOutput("t5 pre tcnt", bus.tcnt, 8'hFF);
    applyStimulus(1'b1, 8'h10, 1'b0, 1'b1, 2'b00);
    stepClock(1);
    checkOutput("t5 load tcnt", bus.tcnt, 8'h10);
    checkOutput("t5 load ovf", bus.ovf, 1'b0);
    applyStimulus(1'b0, 8'h10, 1'b0, 1'b1, 2'b00);
    stepClock(1);
    checkOutput("t5 after+1", bus.tcnt, 8'h10);
    checkOutput("t5 after+1 ovf", bus.ovf, 1'b0);
    stepClock(1);
    checkOutput("t5 after+2", bus.tcnt, 8'h11);

    // Test 6: cks lowered with div_cnt above the new terminal
    applyStimulus(1'b1, 8'h20, 1'b0, 1'b0, 2'b11);
    stepClock(1);
    applyStimulus(1'b0, 8'h20, 1'b0, 1'b1, 2'b11);
    stepClock(9);
    checkOutput("t6 before switch", bus.tcnt, 8'h20);
    applyStimulus(1'b0, 8'h20, 1'b0, 1'b1, 2'b00);
    stepClock(1);
    checkOutput("t6 no tick on clear", bus.tcnt, 8'h20);
    stepClock(1);
    checkOutput("t6 @11", bus.tcnt, 8'h20);
    stepClock(1);
    checkOutput("t6 @12", bus.tcnt, 8'h21);
    stepClock(1);
    checkOutput("t6 @13", bus.tcnt, 8'h21);
    stepClock(1);
    checkOutput("t6 @14", bus.tcnt, 8'h22);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
